mm_exp_sequencer: RTL and testbench

Modular-exponentiation scheduler sitting above the Montgomery multiplier top level. It turns one exponentiation request into an ordered stream of Montgomery multiplications using left-to-right square-and-multiply with leading-zero skip. For each multiplication it tells an external operand mover which bridge-BRAM operand pair to present (`op_o`), pulses the multiplier's start, and waits for its done. It never touches operand data itself.

---
 rtl/mm_exp_pkg.sv | 23 ++
 rtl/mm_exp_sequencer.sv | 141 ++++++++++++++
 tb/tb_mm_exp_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mm_exp_pkg.sv
// Shared types for the modular-exponentiation sequencer: multiplier op codes and FSM states.
package mm_exp_pkg;

    typedef enum logic [2:0] {
        OP_TOMONT_BASE = 3'd0,
        OP_TOMONT_ONE  = 3'd1,
        OP_SQR         = 3'd2,
        OP_MUL         = 3'd3,
        OP_FROMMONT    = 3'd4
    } mm_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_BASE,
        ST_PRE_ONE,
        ST_SCAN_WAIT,
        ST_SQR,
        ST_MUL,
        ST_POST,
        ST_FIN
    } exp_state_t;

endpackage

// File: rtl/mm_exp_sequencer.sv
// Left-to-right square-and-multiply scheduler: one Montgomery op per multiplier start/done handshake.
// Next op issues the cycle after mm_done_i; the multiplier paces the run and start_i is ignored while busy.
module mm_exp_sequencer
    import mm_exp_pkg::*;
#(
    parameter int E_WIDTH   = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [E_WIDTH-1:0]   exp_i,
    input  logic                 mm_done_i,
    output logic                 mm_start_o,
    output mm_op_t               op_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] op_count_o
);

    localparam int BW = $clog2(E_WIDTH);
    localparam logic [BW-1:0]        BIT_ONE = BW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    exp_state_t         state;
    logic [E_WIDTH-1:0] exp_q;
    logic [BW-1:0]      bit_cnt;
    logic               waiting;

    logic msb;
    logic last_bit;
    logic scan_done;
    logic zero_flag;
    logic scan_active;
    logic op_done;

    // exp_q[MSB] is always the bit being processed; bit_cnt is its index in the original exponent.
    assign msb         = exp_q[E_WIDTH-1];
    assign last_bit    = (bit_cnt == '0);
    assign scan_done   = msb | last_bit;
    assign zero_flag   = ~msb & last_bit;
    assign scan_active = ((state == ST_PRE_BASE) || (state == ST_PRE_ONE) ||
                          (state == ST_SCAN_WAIT)) && !scan_done;
    assign op_done     = waiting & mm_done_i;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= ST_IDLE;
            exp_q      <= '0;
            bit_cnt    <= '0;
            waiting    <= 1'b0;
            mm_start_o <= 1'b0;
            op_o       <= OP_TOMONT_BASE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            op_count_o <= '0;
        end else begin
            mm_start_o <= 1'b0;
            done_o     <= 1'b0;
            if (mm_start_o) begin
                waiting <= 1'b1;
            end
            if (scan_active) begin
                exp_q   <= exp_q << 1;
                bit_cnt <= bit_cnt - BIT_ONE;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        exp_q      <= exp_i;
                        bit_cnt    <= BW'(E_WIDTH - 1);
                        busy_o     <= 1'b1;
                        state      <= ST_PRE_BASE;
                        op_o       <= OP_TOMONT_BASE;
                        mm_start_o <= 1'b1;
                        waiting    <= 1'b0;
                        op_count_o <= CNT_ONE;
                    end
                end
                ST_PRE_BASE: begin
                    if (op_done) begin
                        state      <= ST_PRE_ONE;
                        op_o       <= OP_TOMONT_ONE;
                        mm_start_o <= 1'b1;
                        waiting    <= 1'b0;
                        op_count_o <= op_count_o + CNT_ONE;
                    end
                end
                // Pre-ops may outrun the leading-zero scan; hold in SCAN_WAIT until it settles.
                ST_PRE_ONE, ST_SCAN_WAIT: begin
                    if (op_done || (state == ST_SCAN_WAIT)) begin
                        if (scan_done) begin
                            state      <= zero_flag ? ST_POST : ST_SQR;
                            op_o       <= zero_flag ? OP_FROMMONT : OP_SQR;
                            mm_start_o <= 1'b1;
                            waiting    <= 1'b0;
                            op_count_o <= op_count_o + CNT_ONE;
                        end else begin
                            state <= ST_SCAN_WAIT;
                        end
                    end
                end
                ST_SQR, ST_MUL: begin
                    if (op_done) begin
                        mm_start_o <= 1'b1;
                        waiting    <= 1'b0;
                        op_count_o <= op_count_o + CNT_ONE;
                        if ((state == ST_SQR) && msb) begin
                            state <= ST_MUL;
                            op_o  <= OP_MUL;
                        end else if (last_bit) begin
                            state <= ST_POST;
                            op_o  <= OP_FROMMONT;
                        end else begin
                            state   <= ST_SQR;
                            op_o    <= OP_SQR;
                            exp_q   <= exp_q << 1;
                            bit_cnt <= bit_cnt - BIT_ONE;
                        end
                    end
                end
                ST_POST: begin
                    if (op_done) begin
                        state   <= ST_FIN;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        waiting <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_exp_sequencer.sv
// Bench for mm_exp_sequencer: multiplier stub with programmable latency, op-sequence scoreboard.
module tb_mm_exp_sequencer;
    import mm_exp_pkg::*;

    localparam int EW = 64;
    localparam int CW = 16;

    logic          clock_i;
    logic          reset_ni;
    logic          start_i;
    logic [EW-1:0] exp_i;
    logic          mm_done_i;
    logic          mm_start_o;
    mm_op_t        op_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] op_count_o;

    mm_exp_sequencer #(.E_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .start_i    (start_i),
        .exp_i      (exp_i),
        .mm_done_i  (mm_done_i),
        .mm_start_o (mm_start_o),
        .op_o       (op_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .op_count_o (op_count_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Expected op stream, pushed by the stimulus side and popped at every mm_start_o.
    logic [2:0] q_ops[$];

    // Written by the stimulus process only.
    int lat      = 5;
    bit gap_chk  = 1'b0;
    int spur_req = 0;
    int run_id   = 0;

    // Written by the stub process only.
    int         mm_cnt     = 0;
    logic [2:0] cur_op     = 3'd0;
    int         prev_start = -1;
    int         first_sqr  = -1;
    int         last_done  = -1;
    int         done_cyc   = -1;
    int         spur_fired = 0;
    int         seen_run   = 0;

    task automatic push_ops(input logic [EW-1:0] e);
        int h;
        h = -1;
        q_ops.push_back(3'd0);
        q_ops.push_back(3'd1);
        for (int i = 0; i < EW; i++) if (e[i]) h = i;
        for (int i = h; i >= 0; i--) begin
            q_ops.push_back(3'd2);
            if (e[i]) q_ops.push_back(3'd3);
        end
        q_ops.push_back(3'd4);
    endtask

    // Multiplier stub: mm_done_i pulses lat cycles after each observed start.
    initial begin
        mm_done_i = 1'b0;
        forever begin
            @(posedge clock_i);
            #1;
            mm_done_i = 1'b0;
            if (!reset_ni) mm_cnt = 0;
            if (mm_cnt > 0) begin
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mm_done_i = 1'b1;
                    last_done = cyc;
                    check("op_stable", 64'(op_o), 64'(cur_op));
                end
            end
            if (mm_start_o) begin
                if (seen_run != run_id) begin
                    seen_run   = run_id;
                    prev_start = -1;
                    first_sqr  = -1;
                end
                check("op_avail", 64'(q_ops.size() != 0), 64'(1));
                if (q_ops.size() != 0) check("op_seq", 64'(op_o), 64'(q_ops.pop_front()));
                if (gap_chk && prev_start >= 0) check("start_gap", 64'(cyc - prev_start), 64'(2));
                if (op_o == OP_SQR && first_sqr < 0) first_sqr = cyc;
                prev_start = cyc;
                cur_op     = op_o;
                mm_cnt     = lat;
                if (spur_fired < spur_req) begin
                    mm_done_i = 1'b1;
                    spur_fired++;
                end
            end
            if (done_o) begin
                done_cyc = cyc;
                check("busy_at_done", 64'(busy_o), 64'(0));
            end
        end
    end

    task automatic start_run(input logic [EW-1:0] e, input int l, output int acc);
        lat = l;
        run_id++;
        q_ops.delete();
        push_ops(e);
        @(posedge clock_i);
        #1;
        start_i = 1'b1;
        exp_i   = e;
        acc     = cyc;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        exp_i   = '0;
        check("busy_c1", 64'(busy_o), 64'(1));
        check("start_c1", 64'(mm_start_o), 64'(1));
    endtask

    task automatic wait_done(input int acc, input int n, input bit spur);
        int k;
        k = 0;
        while (k < 3000 && !(done_cyc > acc)) begin
            @(posedge clock_i);
            #1;
            if (spur && busy_o && (k % 3 == 0)) begin
                start_i = 1'b1;
                exp_i   = {$urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
            k++;
        end
        start_i = 1'b0;
        check("done_seen", 64'(done_cyc > acc), 64'(1));
        check("done_lat", 64'(done_cyc - last_done), 64'(1));
        check("op_count", 64'(op_count_o), 64'(n));
        check("queue_empty", 64'(q_ops.size()), 64'(0));
        @(posedge clock_i);
        #1;
        check("done_pulse", 64'(done_o), 64'(0));
        check("count_hold", 64'(op_count_o), 64'(n));
    endtask

    task automatic run(input logic [EW-1:0] e, input int l, input bit spur, output int acc);
        int n;
        start_run(e, l, acc);
        n = q_ops.size() + 1;
        wait_done(acc, n, spur);
    endtask

    initial begin
        int acc;
        int k;
        reset_ni = 1'b0;
        start_i  = 1'b0;
        exp_i    = '0;
        repeat (3) @(posedge clock_i);
        #1;
        check("rst_start", 64'(mm_start_o), 64'(0));
        check("rst_op", 64'(op_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_count", 64'(op_count_o), 64'(0));
        @(negedge clock_i);
        reset_ni = 1'b1;

        run(64'h0B, 5, 1'b0, acc);
        check("cnt_0b", 64'(op_count_o), 64'(10));
        run(64'h0, 5, 1'b0, acc);
        check("cnt_zero", 64'(op_count_o), 64'(3));
        check("zero_no_sqr", 64'(first_sqr), 64'(-1));
        gap_chk = 1'b1;
        run({EW{1'b1}}, 1, 1'b0, acc);
        gap_chk = 1'b0;
        check("cnt_ones", 64'(op_count_o), 64'(3 + EW + EW));
        run(64'h1, 1, 1'b0, acc);
        check("scan_wait_sqr", 64'(first_sqr - acc), 64'(EW + 1));
        check("cnt_one", 64'(op_count_o), 64'(5));

        spur_req = spur_fired + 3;
        run(64'h0B, 5, 1'b1, acc);
        check("cnt_spur", 64'(op_count_o), 64'(10));

        // Abort a run while waiting on a MUL, then confirm a clean follow-up run.
        start_run(64'h0B, 5, acc);
        k = 0;
        while (k < 500 && !(op_o == OP_MUL && busy_o && !mm_start_o)) begin
            @(posedge clock_i);
            #1;
            k++;
        end
        check("mul_wait_found", 64'(k < 500), 64'(1));
        @(negedge clock_i);
        reset_ni = 1'b0;
        #1;
        check("abort_start", 64'(mm_start_o), 64'(0));
        check("abort_op", 64'(op_o), 64'(0));
        check("abort_busy", 64'(busy_o), 64'(0));
        check("abort_done", 64'(done_o), 64'(0));
        check("abort_count", 64'(op_count_o), 64'(0));
        repeat (2) @(negedge clock_i);
        reset_ni = 1'b1;
        run(64'h3, 5, 1'b0, acc);
        check("cnt_after_abort", 64'(op_count_o), 64'(7));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
